// File: rtl/vga_timing_gen_if.sv
// Video output bundle between the timing generator and the DAC/LCD side.
// Carries pixel clock, syncs, display enable and 24-bit RGB.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: grid, bars, stream and solid modes.
// Define VGA_UFLOW_CNT_EN to add the saturating uflow_cnt output.
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int GRID   = 16
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        underflow,
  input  logic        uflow_clr,
`ifdef VGA_UFLOW_CNT_EN
  output logic [15:0] uflow_cnt,
`endif
  video_if.master     video_ifm
);

  localparam int HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int VTOT = VDISP + VFP + VPULSE + VBP;
  localparam int XW   = $clog2(HTOT);
  localparam int YW   = $clog2(VTOT);

  localparam logic [XW-1:0] XMAX = XW'(HTOT - 1);
  localparam logic [XW-1:0] HACT = XW'(HDISP);
  localparam logic [XW-1:0] HS0  = XW'(HDISP + HFP);
  localparam logic [XW-1:0] HS1  = XW'(HDISP + HFP + HPULSE);
  localparam logic [XW-1:0] GRX  = XW'(GRID);
  localparam logic [XW-1:0] BWX  = XW'(HDISP / 8);
  localparam logic [YW-1:0] YMAX = YW'(VTOT - 1);
  localparam logic [YW-1:0] VACT = YW'(VDISP);
  localparam logic [YW-1:0] VS0  = YW'(VDISP + VFP);
  localparam logic [YW-1:0] VS1  = YW'(VDISP + VFP + VPULSE);
  localparam logic [YW-1:0] GRY  = YW'(GRID);
  localparam logic          HON  = 1'(HS_POL);
  localparam logic          VON  = 1'(VS_POL);

  logic [XW-1:0] x_q, x_d, bar;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]    mode_q, mode_e;
  logic [2:0]    bar_idx;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, vs_q, blank_q, fs_q, uflow_q;
  logic          active, first, uf_set;

  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == XMAX) begin
      x_d = '0;
      y_d = (y_q == YMAX) ? '0 : y_q + 1'b1;
    end
    first  = (x_q == '0) && (y_q == '0);
    // the new mode already governs pixel (0,0) of the frame it latches on
    mode_e = first ? mode : mode_q;
    active = (x_q < HACT) && (y_q < VACT);
    pix_ready = active && (mode_e == 2'd2) && !pixel_rst;
    uf_set    = pix_ready && !pix_valid;
    bar     = x_q / BWX;
    bar_idx = (bar > XW'(7)) ? 3'd7 : bar[2:0];
    rgb_d   = '0;
    if (active) begin
      unique case (mode_e)
        2'd0: rgb_d = ((x_q % GRX) == '0 || (y_q % GRY) == '0)
                      ? 24'hFFFFFF : 24'h000000;
        2'd1: begin
          unique case (bar_idx)
            3'd0: rgb_d = 24'hFFFFFF;
            3'd1: rgb_d = 24'hFFFF00;
            3'd2: rgb_d = 24'h00FFFF;
            3'd3: rgb_d = 24'h00FF00;
            3'd4: rgb_d = 24'hFF00FF;
            3'd5: rgb_d = 24'hFF0000;
            3'd6: rgb_d = 24'h0000FF;
            3'd7: rgb_d = 24'h000000;
          endcase
        end
        2'd2: rgb_d = pix_valid ? pix_data : 24'h000000;
        2'd3: rgb_d = solid_rgb;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= 2'd0;
      hs_q    <= ~HON;
      vs_q    <= ~VON;
      blank_q <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_e;
      hs_q    <= (x_q >= HS0 && x_q < HS1) ? HON : ~HON;
      vs_q    <= (y_q >= VS0 && y_q < VS1) ? VON : ~VON;
      blank_q <= active;
      rgb_q   <= rgb_d;
      fs_q    <= first;
      uflow_q <= uf_set | (uflow_q & ~uflow_clr);
    end
  end

`ifdef VGA_UFLOW_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      cnt_q <= '0;
    end else if (uflow_clr) begin
      cnt_q <= {15'd0, uf_set};
    end else if (uf_set && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign uflow_cnt = cnt_q;
`endif

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign video_ifm.RGB   = rgb_q;
  assign frame_start     = fs_q;
  assign underflow       = uflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small timings, reference model and scoreboard.
// Second instance runs with active-high syncs.
module tb_vga_timing_gen;

  localparam int HD = 42;
  localparam int HF = 3;
  localparam int HP = 4;
  localparam int HB = 3;
  localparam int VD = 6;
  localparam int VF = 1;
  localparam int VP = 2;
  localparam int VB = 2;
  localparam int GR = 4;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [23:0] solid, pdata;
  logic        pvalid, clr;
  logic        rdy1, fs1, uf1, rdy2, fs2, uf2;
`ifdef VGA_UFLOW_CNT_EN
  logic [15:0] cnt1, cnt2;
`endif

  video_if vif ();
  video_if vif2 ();

  always #5 clk = ~clk;

  vga_timing_gen #(
    .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VFP(VF), .VPULSE(VP), .VBP(VB), .HS_POL(0), .VS_POL(0), .GRID(GR)
  ) u1 (
    .pixel_clk(clk), .pixel_rst(rst), .mode(mode), .solid_rgb(solid),
    .pix_data(pdata), .pix_valid(pvalid), .pix_ready(rdy1),
    .frame_start(fs1), .underflow(uf1), .uflow_clr(clr),
`ifdef VGA_UFLOW_CNT_EN
    .uflow_cnt(cnt1),
`endif
    .video_ifm(vif)
  );

  vga_timing_gen #(
    .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VFP(VF), .VPULSE(VP), .VBP(VB), .HS_POL(1), .VS_POL(1), .GRID(GR)
  ) u2 (
    .pixel_clk(clk), .pixel_rst(rst), .mode(mode), .solid_rgb(solid),
    .pix_data(pdata), .pix_valid(pvalid), .pix_ready(rdy2),
    .frame_start(fs2), .underflow(uf2), .uflow_clr(clr),
`ifdef VGA_UFLOW_CNT_EN
    .uflow_cnt(cnt2),
`endif
    .video_ifm(vif2)
  );

  typedef struct {
    logic        hs, vs, bl, fs, uf;
    logic [23:0] rgb;
    logic [15:0] cnt;
  } exp_t;

  exp_t scb[$];

  int checks = 0;
  int errors = 0;

  int          tx = 0, ty = 0, sdata = 0;
  logic [1:0]  mq = 2'd0;
  logic        muf = 1'b0;
  logic [15:0] mcnt = 16'd0;

  logic [23:0] obs_rgb;
  logic        obs_fs, obs_uf, obs_bl;
  int n_bl, n_hslo, n_vslo, n_fs, n_hs2hi, n_xfer;

  logic [23:0] bar_tbl [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
    24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [23:0] mbar(input int x);
    logic [23:0] r;
    r = bar_tbl[7];
    for (int i = 6; i >= 0; i--)
      if (x < (i + 1) * (HD / 8)) r = bar_tbl[i];
    return r;
  endfunction

  task automatic step();
    exp_t e, g;
    logic rdy, act, f, us;
    logic [1:0] me;
    pdata = sdata[23:0];
    #1;
    rdy = 1'b0;
    me  = 2'd0;
    us  = 1'b0;
    e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.fs = 1'b0;
    e.uf = 1'b0; e.rgb = 24'h0; e.cnt = 16'h0;
    if (!rst) begin
      f   = (tx == 0 && ty == 0);
      me  = f ? mode : mq;
      act = (tx < HD) && (ty < VD);
      rdy = act && (me == 2'd2);
      us  = rdy && !pvalid;
      e.hs = !(tx >= HD + HF && tx < HD + HF + HP);
      e.vs = !(ty >= VD + VF && ty < VD + VF + VP);
      e.bl = act;
      e.fs = f;
      if (act) begin
        case (me)
          2'd0: e.rgb = ((tx % GR) == 0 || (ty % GR) == 0)
                        ? 24'hFFFFFF : 24'h0;
          2'd1: e.rgb = mbar(tx);
          2'd2: e.rgb = pvalid ? pdata : 24'h0;
          default: e.rgb = solid;
        endcase
      end
      e.uf = us || (muf && !clr);
      if (clr) e.cnt = us ? 16'd1 : 16'd0;
      else if (us && mcnt != 16'hFFFF) e.cnt = mcnt + 16'd1;
      else e.cnt = mcnt;
    end
    chk("pix_ready", 32'(rdy1), 32'(rdy));
    chk("pix_ready_pol1", 32'(rdy2), 32'(rdy));
    if (rdy1 && pvalid) n_xfer++;
    scb.push_back(e);
    @(posedge clk);
    #1;
    g = scb.pop_front();
    chk("hs", 32'(vif.HS), 32'(g.hs));
    chk("vs", 32'(vif.VS), 32'(g.vs));
    chk("blank", 32'(vif.BLANK), 32'(g.bl));
    chk("rgb", 32'(vif.RGB), 32'(g.rgb));
    chk("frame_start", 32'(fs1), 32'(g.fs));
    chk("underflow", 32'(uf1), 32'(g.uf));
    chk("hs_pol1", 32'(vif2.HS), 32'(!g.hs));
    chk("vs_pol1", 32'(vif2.VS), 32'(!g.vs));
    chk("blank_pol1", 32'(vif2.BLANK), 32'(g.bl));
    chk("rgb_pol1", 32'(vif2.RGB), 32'(g.rgb));
    chk("frame_start_pol1", 32'(fs2), 32'(g.fs));
    chk("underflow_pol1", 32'(uf2), 32'(g.uf));
`ifdef VGA_UFLOW_CNT_EN
    chk("uflow_cnt", 32'(cnt1), 32'(g.cnt));
    chk("uflow_cnt_pol1", 32'(cnt2), 32'(g.cnt));
`endif
    n_bl    += int'(vif.BLANK);
    n_hslo  += int'(!vif.HS);
    n_vslo  += int'(!vif.VS);
    n_fs    += int'(fs1);
    n_hs2hi += int'(vif2.HS);
    obs_rgb = vif.RGB;
    obs_fs  = fs1;
    obs_uf  = uf1;
    obs_bl  = vif.BLANK;
    if (rst) begin
      tx = 0; ty = 0; mq = 2'd0; muf = 1'b0; mcnt = 16'd0;
    end else begin
      if (rdy && pvalid) sdata++;
      mq   = me;
      muf  = g.uf;
      mcnt = g.cnt;
      tx++;
      if (tx == HT) begin
        tx = 0;
        ty++;
        if (ty == VT) ty = 0;
      end
    end
  endtask

  task automatic run_to(input int x, input int y);
    int n;
    n = 0;
    while (!(tx == x && ty == y) && n < 2000) begin
      step();
      n++;
    end
    chk("run_to_bound", 32'(n < 2000), 32'd1);
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input logic [23:0] e);
    run_to(x, y);
    step();
    chk(tag, 32'(obs_rgb), 32'(e));
  endtask

  task automatic clr_counts();
    n_bl = 0; n_hslo = 0; n_vslo = 0;
    n_fs = 0; n_hs2hi = 0; n_xfer = 0;
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; solid = 24'h123456;
    pvalid = 1'b0; clr = 1'b0; pdata = 24'h0;
    clr_counts();
    repeat (3) step();
    rst = 1'b0;

    clr_counts();
    step();
    chk("first_frame_start", 32'(obs_fs), 32'd1);
    repeat (HT * VT - 1) step();
    chk("blank_cycles", n_bl, 32'd252);
    chk("hs_low_cycles", n_hslo, 32'd44);
    chk("vs_low_cycles", n_vslo, 32'd104);
    chk("frame_starts", n_fs, 32'd1);
    chk("hs_pol1_high_cycles", n_hs2hi, 32'd44);

    pix("grid_16_3", 16, 3, 24'hFFFFFF);
    pix("grid_0_5", 0, 5, 24'hFFFFFF);
    pix("grid_5_5", 5, 5, 24'h000000);
    pix("grid_5_4", 5, 4, 24'hFFFFFF);

    run_to(20, 3);
    rst = 1'b1;
    repeat (3) step();
    chk("rst_rgb", 32'(obs_rgb), 32'd0);
    chk("rst_blank", 32'(obs_bl), 32'd0);
    chk("rst_hs", 32'(vif.HS), 32'd1);
    chk("rst_vs", 32'(vif.VS), 32'd1);
    chk("rst_underflow", 32'(obs_uf), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_frame_start", 32'(obs_fs), 32'd1);

    run_to(10, 2);
    mode = 2'd1;
    pix("grid_hold_5_5", 5, 5, 24'h000000);
    pix("grid_hold_0_5", 8, 5, 24'hFFFFFF);
    pix("bar_4_0", 4, 0, 24'hFFFFFF);
    pix("bar_5_0", 5, 0, 24'hFFFF00);
    pix("bar_34_1", 34, 1, 24'h0000FF);
    pix("bar_35_1", 35, 1, 24'h000000);
    pix("bar_41_5", 41, 5, 24'h000000);

    run_to(0, 3);
    sdata = 0;
    mode = 2'd2;
    pvalid = 1'b1;
    run_to(0, 0);
    clr_counts();
    repeat (HT * VT) step();
    chk("stream_xfers", n_xfer, 32'd252);
    chk("stream_no_uflow", 32'(obs_uf), 32'd0);
    pix("stream_10_2", 10, 2, 24'd346);
    run_to(10, 3);
    pvalid = 1'b0;
    step();
    chk("uflow_rgb", 32'(obs_rgb), 32'd0);
    chk("uflow_set", 32'(obs_uf), 32'd1);
    pvalid = 1'b1;
    step();
    chk("uflow_next_word", 32'(obs_rgb), 32'd388);
`ifdef VGA_UFLOW_CNT_EN
    chk("uflow_cnt_one", 32'(cnt1), 32'd1);
`endif
    run_to(30, 4);
    chk("uflow_sticky", 32'(obs_uf), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("uflow_cleared", 32'(obs_uf), 32'd0);
    run_to(5, 5);
    pvalid = 1'b0;
    clr = 1'b1;
    step();
    chk("uflow_set_wins", 32'(obs_uf), 32'd1);
    pvalid = 1'b1;
    clr = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("uflow_cleared2", 32'(obs_uf), 32'd0);

    mode = 2'd3;
    solid = 24'hA5C33C;
    run_to(0, 0);
    pix("solid_3_1", 3, 1, 24'hA5C33C);
    pix("solid_blank", 45, 1, 24'h000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
